// File: rtl/uart_cmd_master.sv
// Host-side initiator for the UART command protocol: serialises one command into frame bytes
// for a UART transmitter, then gathers response bytes from a UART receiver.
module uart_cmd_master #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned ALU_FUN_WIDTH  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                      i_CLK,
   input  logic                      i_RST,
   input  logic                      i_CMD_VALID,
   output logic                      o_CMD_READY,
   input  logic [1:0]                i_CMD_TYPE,
   input  logic [ADDR_WIDTH-1:0]     i_ADDR,
   input  logic [DATA_WIDTH-1:0]     i_WR_DATA,
   input  logic [DATA_WIDTH-1:0]     i_OP_A,
   input  logic [DATA_WIDTH-1:0]     i_OP_B,
   input  logic [ALU_FUN_WIDTH-1:0]  i_ALU_FUN,
   output logic [DATA_WIDTH-1:0]     o_TX_P_DATA,
   output logic                      o_TX_D_VLD,
   input  logic                      i_TX_BUSY,
   input  logic [DATA_WIDTH-1:0]     i_RX_P_DATA,
   input  logic                      i_RX_D_VLD,
   output logic [2*DATA_WIDTH-1:0]   o_RSP_DATA,
   output logic                      o_RSP_VALID,
   output logic                      o_TIMEOUT,
   output logic                      o_BUSY
);

   localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
   localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);

   localparam logic [1:0] CmdRfWr   = 2'd0;
   localparam logic [1:0] CmdRfRd   = 2'd1;
   localparam logic [1:0] CmdAluOp  = 2'd2;
   localparam logic [1:0] CmdAluNop = 2'd3;

   localparam logic [DATA_WIDTH-1:0] SyncRfWr   = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] SyncRfRd   = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] SyncAluOp  = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] SyncAluNop = DATA_WIDTH'(8'hDD);

   typedef enum logic [2:0] {
      StIdle,
      StSend,
      StWaitHi,
      StWaitLo,
      StRecv,
      StResp,
      StAbort
   } state_e;

   state_e                         state_q, state_d;
   logic [3:0][DATA_WIDTH-1:0]     frame_q, frame_d;
   logic [1:0]                     last_idx_q, last_idx_d;
   logic [1:0]                     rsp_len_q, rsp_len_d;
   logic [1:0]                     idx_q;
   logic                           rsp_idx_q;
   logic [TimerW-1:0]              timer_q;
   logic [DATA_WIDTH-1:0]          tx_data_q;
   logic                           tx_vld_q;
   logic [2*DATA_WIDTH-1:0]        rsp_data_q;

   logic accept, tx_fire, rx_take, timer_exp, frame_last, rsp_last;
   logic timer_clr, timer_run, recv_entry;

   assign accept     = (state_q == StIdle) && i_CMD_VALID;
   assign tx_fire    = (state_q == StSend) && !i_TX_BUSY;
   assign rx_take    = (state_q == StRecv) && i_RX_D_VLD;
   assign timer_exp  = (timer_q == TimerLast);
   assign frame_last = (idx_q == last_idx_q);
   assign rsp_last   = (({1'b0, rsp_idx_q} + 2'd1) == rsp_len_q);
   assign recv_entry = (state_d == StRecv) && (state_q != StRecv);
   assign timer_run  = (state_q == StWaitHi) || (state_q == StRecv);
   assign timer_clr  = ((state_d == StWaitHi) && (state_q != StWaitHi)) || recv_entry || rx_take;

   // Whole frame is built at accept time so command inputs are free afterwards.
   always_comb begin
      frame_d    = '0;
      last_idx_d = 2'd0;
      rsp_len_d  = 2'd0;
      unique case (i_CMD_TYPE)
         CmdRfWr: begin
            frame_d[0] = SyncRfWr;
            frame_d[1] = DATA_WIDTH'(i_ADDR);
            frame_d[2] = i_WR_DATA;
            last_idx_d = 2'd2;
            rsp_len_d  = 2'd0;
         end
         CmdRfRd: begin
            frame_d[0] = SyncRfRd;
            frame_d[1] = DATA_WIDTH'(i_ADDR);
            last_idx_d = 2'd1;
            rsp_len_d  = 2'd1;
         end
         CmdAluOp: begin
            frame_d[0] = SyncAluOp;
            frame_d[1] = i_OP_A;
            frame_d[2] = i_OP_B;
            frame_d[3] = DATA_WIDTH'(i_ALU_FUN);
            last_idx_d = 2'd3;
            rsp_len_d  = 2'd2;
         end
         CmdAluNop: begin
            frame_d[0] = SyncAluNop;
            frame_d[1] = DATA_WIDTH'(i_ALU_FUN);
            last_idx_d = 2'd1;
            rsp_len_d  = 2'd2;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (i_CMD_VALID) state_d = StSend;
         StSend:   if (!i_TX_BUSY) state_d = StWaitHi;
         StWaitHi: begin
            if (i_TX_BUSY) begin
               state_d = StWaitLo;
            end else if (timer_exp) begin
               state_d = StAbort;
            end
         end
         StWaitLo: begin
            if (!i_TX_BUSY) begin
               if (!frame_last) begin
                  state_d = StSend;
               end else if (rsp_len_q == 2'd0) begin
                  state_d = StIdle;
               end else begin
                  state_d = StRecv;
               end
            end
         end
         StRecv: begin
            // An RX byte wins over a same-cycle timer expiry.
            if (i_RX_D_VLD) begin
               if (rsp_last) state_d = StResp;
            end else if (timer_exp) begin
               state_d = StAbort;
            end
         end
         StResp:   state_d = StIdle;
         StAbort:  state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      o_CMD_READY = (state_q == StIdle);
      o_BUSY      = (state_q != StIdle);
      o_RSP_VALID = (state_q == StResp);
      o_TIMEOUT   = (state_q == StAbort);
      o_TX_D_VLD  = tx_vld_q;
      o_TX_P_DATA = tx_data_q;
      o_RSP_DATA  = rsp_data_q;
   end

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         frame_q    <= '0;
         last_idx_q <= 2'd0;
         rsp_len_q  <= 2'd0;
         idx_q      <= 2'd0;
         rsp_idx_q  <= 1'b0;
         timer_q    <= '0;
         tx_data_q  <= '0;
         tx_vld_q   <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         tx_vld_q <= tx_fire;
         if (tx_fire) begin
            tx_data_q <= frame_q[idx_q];
         end

         if (accept) begin
            frame_q    <= frame_d;
            last_idx_q <= last_idx_d;
            rsp_len_q  <= rsp_len_d;
            idx_q      <= 2'd0;
         end else if ((state_q == StWaitLo) && !i_TX_BUSY && !frame_last) begin
            idx_q <= idx_q + 2'd1;
         end

         if (timer_clr) begin
            timer_q <= '0;
         end else if (timer_run) begin
            timer_q <= timer_q + TimerOne;
         end

         if (recv_entry) begin
            rsp_data_q <= '0;
            rsp_idx_q  <= 1'b0;
         end else if (rx_take) begin
            if (rsp_idx_q) begin
               rsp_data_q[2*DATA_WIDTH-1:DATA_WIDTH] <= i_RX_P_DATA;
            end else begin
               rsp_data_q[DATA_WIDTH-1:0] <= i_RX_P_DATA;
            end
            rsp_idx_q <= ~rsp_idx_q;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Self-checking bench for uart_cmd_master: a busy-pulse TX model, an RX byte driver and a
// frame/response reference built from the command protocol table.
module tb_uart_cmd_master;

   localparam int unsigned TO = 64;

   logic        clk, rst_n;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_type;
   logic [3:0]  addr, alu_fun;
   logic [7:0]  wr_data, op_a, op_b;
   logic [7:0]  tx_p_data, rx_p_data;
   logic        tx_d_vld, tx_busy, rx_d_vld;
   logic [15:0] rsp_data;
   logic        rsp_valid, timeout, busy;

   uart_cmd_master #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_CLK(clk), .i_RST(rst_n), .i_CMD_VALID(cmd_valid), .o_CMD_READY(cmd_ready),
      .i_CMD_TYPE(cmd_type), .i_ADDR(addr), .i_WR_DATA(wr_data), .i_OP_A(op_a),
      .i_OP_B(op_b), .i_ALU_FUN(alu_fun), .o_TX_P_DATA(tx_p_data), .o_TX_D_VLD(tx_d_vld),
      .i_TX_BUSY(tx_busy), .i_RX_P_DATA(rx_p_data), .i_RX_D_VLD(rx_d_vld),
      .o_RSP_DATA(rsp_data), .o_RSP_VALID(rsp_valid), .o_TIMEOUT(timeout), .o_BUSY(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  tx_log[$];
   int          busy_left = 0;
   int          tx_len = 10;
   bit          tx_stuck = 0;
   int          rsp_cnt = 0;
   int          to_cnt = 0;

   // TX model: raises busy the cycle after each strobe and holds it for tx_len cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
         end
         if (tx_d_vld) begin
            tx_log.push_back(tx_p_data);
            if (!tx_stuck) begin
               tx_busy   = 1'b1;
               busy_left = tx_len;
            end
         end
         if (rsp_valid) rsp_cnt++;
         if (timeout) to_cnt++;
      end
   end

   function automatic int frame_len(input logic [1:0] t);
      case (t)
         2'd0: return 3;
         2'd2: return 4;
         default: return 2;
      endcase
   endfunction

   function automatic int rsp_len(input logic [1:0] t);
      case (t)
         2'd0: return 0;
         2'd1: return 1;
         default: return 2;
      endcase
   endfunction

   // Byte i of the frame sits at bits [8*i +: 8].
   function automatic logic [31:0] frame_bytes(input logic [1:0] t, input logic [3:0] ad,
                                               input logic [7:0] wd, input logic [7:0] a,
                                               input logic [7:0] b, input logic [3:0] fn);
      case (t)
         2'd0:    return {8'h00, wd, {4'h0, ad}, 8'hAA};
         2'd1:    return {16'h0000, {4'h0, ad}, 8'hBB};
         2'd2:    return {{4'h0, fn}, b, a, 8'hCC};
         default: return {16'h0000, {4'h0, fn}, 8'hDD};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_d_vld  = 1'b1;
      rx_p_data = b;
      tick(1);
      rx_d_vld  = 1'b0;
      rx_p_data = 8'($urandom);
   endtask

   task automatic wait_ready(input string tag, input int lim);
      int k = 0;
      while (!cmd_ready && k < lim) begin
         tick(1);
         k++;
      end
      chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
   endtask

   task automatic wait_tx(input string tag, input int n);
      int k = 0;
      while (tx_log.size() < n && k < 400) begin
         tick(1);
         k++;
      end
      chk({tag, " tx count"}, tx_log.size(), n);
   endtask

   task automatic wait_tx_idle();
      int k = 0;
      while (tx_busy && k < 100) begin
         tick(1);
         k++;
      end
   endtask

   task automatic issue(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] wd,
                        input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn);
      tx_log.delete();
      cmd_valid = 1'b1;
      cmd_type  = t;
      addr      = ad;
      wr_data   = wd;
      op_a      = a;
      op_b      = b;
      alu_fun   = fn;
      tick(1);
      cmd_valid = 1'b0;
      cmd_type  = 2'($urandom);
      addr      = 4'($urandom);
      wr_data   = 8'($urandom);
      op_a      = 8'($urandom);
      op_b      = 8'($urandom);
      alu_fun   = 4'($urandom);
   endtask

   task automatic check_frame(input string tag, input int len, input logic [31:0] fr);
      chk({tag, " frame len"}, tx_log.size(), len);
      for (int i = 0; i < len; i++) begin
         chk($sformatf("%s tx byte%0d", tag, i),
             (i < tx_log.size()) ? {24'h0, tx_log[i]} : 32'hFFFF_FFFF,
             {24'h0, fr[8*i +: 8]});
      end
   endtask

   // Full command that completes normally; response bytes returned by the RX driver.
   task automatic run_cmd(input string tag, input logic [1:0] t, input logic [3:0] ad,
                          input logic [7:0] wd, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] fn, input logic [7:0] rx0, input logic [7:0] rx1);
      int          len  = frame_len(t);
      int          nrsp = rsp_len(t);
      logic [31:0] fr   = frame_bytes(t, ad, wd, a, b, fn);
      int          rc0  = rsp_cnt;
      int          tc0  = to_cnt;
      logic [15:0] prev = rsp_data;
      logic [15:0] exp_rsp;
      issue(t, ad, wd, a, b, fn);
      chk({tag, " busy after accept"}, {busy, cmd_ready}, 32'b10);
      tick(1);
      chk({tag, " first strobe"}, 32'(tx_d_vld), 32'd1);
      wait_tx(tag, len);
      wait_tx_idle();
      tick(2);
      if (nrsp > 0) begin
         tick($urandom_range(0, 3));
         send_rx(rx0);
      end
      if (nrsp > 1) begin
         tick($urandom_range(0, 3));
         send_rx(rx1);
      end
      wait_ready(tag, 4 * TO);
      exp_rsp = (nrsp == 0) ? prev : (nrsp == 1) ? {8'h00, rx0} : {rx1, rx0};
      check_frame(tag, len, fr);
      chk({tag, " tx data held"}, {24'h0, tx_p_data}, {24'h0, fr[8*(len-1) +: 8]});
      chk({tag, " rsp pulses"}, rsp_cnt - rc0, (nrsp > 0) ? 1 : 0);
      chk({tag, " timeouts"}, to_cnt - tc0, 0);
      chk({tag, " rsp data"}, {16'h0, rsp_data}, {16'h0, exp_rsp});
   endtask

   initial begin
      int          k;
      int          rc0;
      logic [15:0] prev;
      logic [1:0]  t;

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_type  = 2'd0;
      addr      = 4'h0;
      wr_data   = 8'h00;
      op_a      = 8'h00;
      op_b      = 8'h00;
      alu_fun   = 4'h0;
      rx_d_vld  = 1'b0;
      rx_p_data = 8'h00;
      tick(3);
      chk("reset ready", 32'(cmd_ready), 32'd1);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset tx_vld", 32'(tx_d_vld), 32'd0);
      chk("reset tx_data", {24'h0, tx_p_data}, 32'h0);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_data", {16'h0, rsp_data}, 32'h0);
      chk("reset timeout", 32'(timeout), 32'd0);
      rst_n = 1'b1;
      tick(2);

      tx_len = 10;
      run_cmd("rf_wr", 2'd0, 4'h3, 8'h5A, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00);
      run_cmd("rf_rd", 2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 8'h81, 8'h00);
      run_cmd("alu_op", 2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0, 8'h46, 8'h00);

      // ALU_NO_OP with only one of two response bytes returned.
      rc0 = rsp_cnt;
      issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
      wait_tx("nop_to", 2);
      wait_tx_idle();
      tick(2);
      send_rx(8'hF0);
      k = 0;
      while (!timeout && k < 2 * TO) begin
         tick(1);
         k++;
      end
      chk("nop_to latency", k, TO);
      check_frame("nop_to", 2, frame_bytes(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2));
      chk("nop_to rsp pulses", rsp_cnt - rc0, 0);
      chk("nop_to rsp data", {16'h0, rsp_data}, 32'h00F0);
      tick(1);
      chk("nop_to pulse width", 32'(timeout), 32'd0);
      chk("nop_to ready", 32'(cmd_ready), 32'd1);

      // RX strobes while idle must be discarded.
      prev = rsp_data;
      rc0  = rsp_cnt;
      send_rx(8'h11);
      tick(1);
      send_rx(8'h22);
      send_rx(8'h33);
      tick(2);
      chk("idle rx ready", 32'(cmd_ready), 32'd1);
      chk("idle rx rsp data", {16'h0, rsp_data}, {16'h0, prev});
      chk("idle rx rsp pulses", rsp_cnt - rc0, 0);

      // TX never raises busy after the strobe.
      tx_stuck = 1'b1;
      rc0      = rsp_cnt;
      issue(2'd1, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0);
      tick(1);
      chk("stuck strobe", 32'(tx_d_vld), 32'd1);
      k = 0;
      while (!timeout && k < 2 * TO) begin
         tick(1);
         k++;
      end
      chk("stuck latency", k, TO);
      chk("stuck frame len", tx_log.size(), 1);
      chk("stuck rsp pulses", rsp_cnt - rc0, 0);
      tick(1);
      chk("stuck ready", 32'(cmd_ready), 32'd1);
      tx_stuck = 1'b0;

      // Reset asserted while the second byte of an ALU_W_OP frame is in flight.
      tx_len = 10;
      issue(2'd2, 4'h0, 8'h00, 8'hA5, 8'h5A, 4'h9);
      wait_tx("rst_mid", 2);
      tick(3);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid async ready", 32'(cmd_ready), 32'd1);
      chk("rst_mid async outs", {busy, tx_d_vld, rsp_valid, timeout}, 32'h0);
      chk("rst_mid async data", {8'h0, tx_p_data, rsp_data}, 32'h0);
      @(posedge clk); #1;
      chk("rst_mid edge ready", 32'(cmd_ready), 32'd1);
      chk("rst_mid edge busy", 32'(busy), 32'd0);
      tick(2);
      rst_n = 1'b1;
      wait_tx_idle();
      tick(5);
      chk("rst_mid no more tx", tx_log.size(), 2);
      chk("rst_mid idle", {busy, cmd_ready}, 32'b01);

      // Randomised commands against the frame/response reference.
      for (int i = 0; i < 24; i++) begin
         t      = 2'($urandom);
         tx_len = $urandom_range(1, 12);
         run_cmd($sformatf("rnd%0d", i), t, 4'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 4'($urandom), 8'($urandom), 8'($urandom));
         tick($urandom_range(0, 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
